fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of ASYNC_FIFO among NREQ requesters in the write-clock domain.
- Each requester presents a valid/ready stream. The arbiter grants one requester at a time, for up to MAX_BURST words.
- It drives w_enable/w_data straight into the FIFO and never writes while full is high.
- The FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of an async FIFO among
// NREQ valid/ready requesters, granting up to MAX_BURST words per turn.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    full,
  output logic                    w_enable,
  output logic [WIDTH-1:0]        w_data,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [15:0]             xfer_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IW-1:0]   g_idx, g_idx_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic [IW-1:0]   pick_base;
  logic [IW:0]     sel;
  logic            release_g;

  // Returns {found, index} of the first valid requester scanning from base.
  function automatic logic [IW:0] pick(input logic [NREQ-1:0] v,
                                       input logic [IW-1:0]   base);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] jj;
    int            j;
    found = 1'b0;
    idx   = base;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(base) + k) % NREQ;
      jj = IW'(j);
      if (!found && v[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IW-1:0] next_of(input logic [IW-1:0] g);
    return (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
  endfunction

  assign busy = (state == GRANT);

  // Write path is combinational from the registered grant so the full flag
  // seen this cycle already accounts for every earlier write.
  always_comb begin
    req_ready = '0;
    w_enable  = 1'b0;
    w_data    = '0;
    if (aresetn && state == GRANT && req_valid[g_idx] && !full) begin
      req_ready = grant;
      w_enable  = 1'b1;
      w_data    = req_data[g_idx*WIDTH +: WIDTH];
    end
  end

  assign pick_base = (state == GRANT) ? next_of(g_idx) : rr_ptr;
  assign sel       = pick(req_valid, pick_base);
  assign release_g = (state == GRANT) &&
                     (!req_valid[g_idx] ||
                      (w_enable && burst_cnt == BW'(MAX_BURST - 1)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_n = state;
    grant_n = grant;
    g_idx_n = g_idx;
    rr_n    = rr_ptr;
    burst_n = burst_cnt;
    case (state)
      IDLE: begin
        if (sel[IW]) begin
          state_n = GRANT;
          g_idx_n = sel[IW-1:0];
          grant_n = NREQ'(1) << sel[IW-1:0];
          burst_n = '0;
        end
      end
      GRANT: begin
        if (w_enable) burst_n = burst_cnt + BW'(1);
        if (release_g) begin
          // Re-arbitrate in the release cycle so back-to-back grants
          // have no idle bubble.
          rr_n    = pick_base;
          burst_n = '0;
          if (sel[IW]) begin
            g_idx_n = sel[IW-1:0];
            grant_n = NREQ'(1) << sel[IW-1:0];
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      g_idx      <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      xfer_count <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      g_idx     <= g_idx_n;
      rr_ptr    <= rr_n;
      burst_cnt <= burst_n;
      if (w_enable) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule
